// File: rtl/div_pkg.sv
// Shared widths and FSM state encoding for the sequential restoring divider.
package div_pkg;
    localparam int DIVIDEND_W_DEF = 6;
    localparam int DIVISOR_W_DEF  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only when it did not borrow.
module div_step #(
    parameter int DIVISOR_W = 3
) (
    input  logic [DIVISOR_W-1:0] prem_in,
    input  logic                 next_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic                 q_bit,
    output logic [DIVISOR_W:0]   prem_out
);
    logic [DIVISOR_W:0]   shifted;
    logic [DIVISOR_W+1:0] trial;

    assign shifted  = {prem_in, next_bit};
    assign trial    = {1'b0, shifted} - {2'b00, divisor};
    assign q_bit    = ~trial[DIVISOR_W+1];
    assign prem_out = q_bit ? trial[DIVISOR_W:0] : shifted;
endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider: one restoring step per cycle, MSB first,
// with a valid/ready result hand-off and divide-by-zero flagging.
module seq_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  in_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int              CNT_W     = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

    div_state_e state, state_nxt;

    logic [CNT_W-1:0]      step_cnt;
    logic [DIVIDEND_W-1:0] dvd_sh;   // dividend bits shift out the top, quotient bits in the bottom
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [DIVISOR_W-1:0]  prem;
    logic                  q_bit;
    logic [DIVISOR_W:0]    step_rem;
    logic [DIVIDEND_W-1:0] quo_nxt;
    logic                  accept, xfer, last_step;
    logic                  unused_prem_msb;

    assign in_ready  = (state == IDLE);
    assign accept    = start && (state == IDLE);
    assign xfer      = out_valid && out_ready;
    assign last_step = (step_cnt == LAST_STEP);
    assign quo_nxt   = {dvd_sh[DIVIDEND_W-2:0], q_bit};

    // A restored remainder is always below the divisor, so its top bit is zero.
    assign unused_prem_msb = step_rem[DIVISOR_W];

    div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .prem_in  (prem),
        .next_bit (dvd_sh[DIVIDEND_W-1]),
        .divisor  (dvs_q),
        .q_bit    (q_bit),
        .prem_out (step_rem)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (divisor == '0) ? DONE : RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    if (xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_cnt    <= '0;
            dvd_sh      <= '0;
            dvs_q       <= '0;
            prem        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd_sh   <= dividend;
                        dvs_q    <= divisor;
                        prem     <= '0;
                        step_cnt <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    dvd_sh   <= quo_nxt;
                    prem     <= step_rem[DIVISOR_W-1:0];
                    step_cnt <= step_cnt + CNT_W'(1);
                    if (last_step) begin
                        quotient    <= quo_nxt;
                        remainder   <= step_rem[DIVISOR_W-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
            out_valid <= (state_nxt == DONE);
        end
    end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter DIVIDEND_W, default 6, dividend and quotient width.
REQ-002 Parameter DIVISOR_W, default 3, divisor and remainder width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous reset, active-low.
REQ-005 start  input  1  request; accepted when start && in_ready.
REQ-006 dividend  input  DIVIDEND_W  numerator (unsigned), sampled on accept.
REQ-007 divisor  input  DIVISOR_W  denominator (unsigned), sampled on accept.
REQ-008 in_ready  output  1  high only in IDLE.
REQ-009 quotient  output  DIVIDEND_W  result quotient, valid with out_valid.
REQ-010 remainder  output  DIVISOR_W  result remainder, valid with out_valid.
REQ-011 div_by_zero  output  1  set with result when captured divisor == 0.
REQ-012 out_valid  output  1  result available; held until consumed.
REQ-013 out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE.
REQ-015 IDLE: on accept, capture operands; divisor != 0 -> RUN with step count 0; divisor == 0 -> DONE.
REQ-016 RUN SHALL perform one restoring step per cycle, MSB of dividend first: partial remainder (DIVISOR_W+1 bits) shifted left with next dividend bit, trial subtract divisor, quotient bit = no-borrow, remainder restored on borrow.
REQ-017 RUN SHALL last exactly DIVIDEND_W cycles, then go to DONE.
REQ-018 Latency: accept in cycle T -> out_valid first high in cycle T+DIVIDEND_W+1 (T+1 for divide-by-zero).
REQ-019 Result SHALL satisfy dividend == quotient*divisor + remainder, remainder < divisor, all unsigned.
REQ-020 Divide-by-zero: quotient all ones, remainder 0, div_by_zero 1.
REQ-021 DONE: outputs stable while out_valid && !out_ready; on transfer -> IDLE, out_valid low next cycle.
REQ-022 start while not in IDLE SHALL be ignored (no queuing); in_ready low in RUN and DONE.
REQ-023 New request SHALL NOT be accepted in the same cycle as a result transfer; earliest accept is the cycle after.
REQ-024 quotient, remainder, div_by_zero SHALL hold last result after transfer until the next result is loaded.
REQ-025 out_valid SHALL be registered; no combinational path from start or operands to any output.

Reset
REQ-026 rst_n low at a rising edge: state IDLE, in_ready 1 (next cycle), out_valid 0, quotient 0, remainder 0, div_by_zero 0, step count 0.
REQ-027 Reset mid-RUN or mid-DONE SHALL abort the operation; pending result discarded, no out_valid.
REQ-028 Reset SHALL take priority over start and out_ready in the same cycle.

Structure
REQ-029 Shared package div_pkg SHALL hold default widths and the FSM state enum (IDLE, RUN, DONE).
REQ-030 One sub-module div_step SHALL implement a single combinational restoring step (inputs partial remainder, next bit, divisor; outputs quotient bit, new partial remainder); seq_divider instantiates it once and iterates.
REQ-031 Step counter width SHALL be $clog2(DIVIDEND_W+1).

Verification
REQ-032 45 / 6, out_ready 1 -> out_valid in cycle T+7, quotient 7, remainder 3, div_by_zero 0.
REQ-033 63 / 7 -> quotient 9, remainder 0; 5 / 7 -> quotient 0, remainder 5.
REQ-034 20 / 0 -> out_valid in cycle T+1, quotient 63, remainder 0, div_by_zero 1.
REQ-035 45 / 6 with out_ready held low 5 cycles after out_valid -> outputs stable for all 5 cycles; start pulsed meanwhile ignored; in_ready 1 the cycle after transfer.
REQ-036 rst_n low at RUN step 3 of 45 / 6 -> next cycle IDLE, in_ready 1, out_valid 0; following 9 / 2 -> quotient 4, remainder 1.
REQ-037 Exhaustive sweep all 64x8 operand pairs back-to-back -> every result matches REQ-019/REQ-020.
